// File: rtl/core_pkg.sv
// Shared types for the pipeline stall/flush controller.
package core_pkg;

    typedef enum logic [2:0] {
        NONE,
        DMEM,
        EXBUSY,
        REDIRECT,
        DEP,
        IMEM
    } hazard_cause_e;

    typedef enum logic {
        IDLE,
        DROP
    } redir_state_e;

endpackage

// File: rtl/hazard_dep_check.sv
// Source/destination matching that decides whether the instruction in ID
// must wait for a producer still in EX or MEM.
module hazard_dep_check #(
    parameter bit          BRANCH_IN_ID   = 1'b0,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_id_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_id_i,
    input  logic                      rs1_used_id_i,
    input  logic                      rs2_used_id_i,
    input  logic                      is_branch_id_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_ex_i,
    input  logic                      RegWrite_ex_i,
    input  logic                      is_load_ex_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_mem_i,
    input  logic                      is_load_mem_i,
    output logic                      dep_stall
);

    logic ex_hit;
    logic mem_hit;
    logic load_use;
    logic branch_dep;

    always_comb begin
        ex_hit  = ((rs1_used_id_i && (rs1_addr_id_i == rd_addr_ex_i)) ||
                   (rs2_used_id_i && (rs2_addr_id_i == rd_addr_ex_i))) &&
                  (rd_addr_ex_i != '0);
        mem_hit = ((rs1_used_id_i && (rs1_addr_id_i == rd_addr_mem_i)) ||
                   (rs2_used_id_i && (rs2_addr_id_i == rd_addr_mem_i))) &&
                  (rd_addr_mem_i != '0);

        load_use = is_load_ex_i && RegWrite_ex_i && ex_hit;

        // A branch compared in ID cannot use the EX forward of an ALU result,
        // nor a load result still in MEM.
        branch_dep = is_branch_id_i &&
                     ((RegWrite_ex_i && ex_hit) || (is_load_mem_i && mem_hit));

        dep_stall = load_use || (BRANCH_IN_ID && branch_dep);
    end

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Central stall/flush controller: prioritises hazards, squashes stale fetches
// after a redirect and keeps saturating stall/flush counters.
module pipeline_ctrl_unit
    import core_pkg::*;
#(
    parameter bit          BRANCH_IN_ID   = 1'b0,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_id_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_id_i,
    input  logic                      rs1_used_id_i,
    input  logic                      rs2_used_id_i,
    input  logic                      is_branch_id_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_ex_i,
    input  logic                      RegWrite_ex_i,
    input  logic                      is_load_ex_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_mem_i,
    input  logic                      is_load_mem_i,
    input  logic                      PCSrc_i,
    input  logic                      fetch_pending_i,
    input  logic                      imem_rvalid_i,
    input  logic                      dmem_busy_i,
    input  logic                      ex_busy_i,
    input  logic                      cnt_clr_i,
    output logic                      pc_we_o,
    output logic                      if_id_stall_o,
    output logic                      if_id_flush_o,
    output logic                      id_ex_stall_o,
    output logic                      id_ex_flush_o,
    output logic                      ex_mem_stall_o,
    output logic                      ex_mem_flush_o,
    output logic                      mem_wb_flush_o,
    output logic                      redirect_o,
    output logic [CNT_WIDTH-1:0]      stall_cnt_o,
    output logic [CNT_WIDTH-1:0]      flush_cnt_o
);

    logic                 dep_stall;
    logic                 imem_wait;
    logic                 stale_rsp;
    hazard_cause_e        cause;
    redir_state_e         state_q, state_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    // Unmasked controls; reset masking is applied only at the ports.
    logic pc_we, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic ex_mem_stall, ex_mem_flush, mem_wb_flush, redirect;

    hazard_dep_check #(
        .BRANCH_IN_ID  (BRANCH_IN_ID),
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_dep (
        .rs1_addr_id_i (rs1_addr_id_i),
        .rs2_addr_id_i (rs2_addr_id_i),
        .rs1_used_id_i (rs1_used_id_i),
        .rs2_used_id_i (rs2_used_id_i),
        .is_branch_id_i(is_branch_id_i),
        .rd_addr_ex_i  (rd_addr_ex_i),
        .RegWrite_ex_i (RegWrite_ex_i),
        .is_load_ex_i  (is_load_ex_i),
        .rd_addr_mem_i (rd_addr_mem_i),
        .is_load_mem_i (is_load_mem_i),
        .dep_stall     (dep_stall)
    );

    always_comb begin
        imem_wait = fetch_pending_i && !imem_rvalid_i;
        stale_rsp = (state_q == DROP) && imem_rvalid_i;

        cause = NONE;
        if (dmem_busy_i)                  cause = DMEM;
        else if (ex_busy_i)               cause = EXBUSY;
        else if (PCSrc_i)                 cause = REDIRECT;
        else if (dep_stall)               cause = DEP;
        else if (imem_wait || stale_rsp)  cause = IMEM;
    end

    always_comb begin
        pc_we        = 1'b1;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        redirect     = 1'b0;
        case (cause)
            DMEM: begin
                pc_we        = 1'b0;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_flush = 1'b1;
            end
            EXBUSY: begin
                pc_we        = 1'b0;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_flush = 1'b1;
            end
            REDIRECT: begin
                redirect    = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = !BRANCH_IN_ID;
            end
            DEP: begin
                pc_we       = 1'b0;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
            IMEM: begin
                pc_we       = 1'b0;
                if_id_flush = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        if (!rst_n) begin
            pc_we_o        = 1'b0;
            if_id_stall_o  = 1'b1;
            if_id_flush_o  = 1'b0;
            id_ex_stall_o  = 1'b1;
            id_ex_flush_o  = 1'b0;
            ex_mem_stall_o = 1'b1;
            ex_mem_flush_o = 1'b0;
            mem_wb_flush_o = 1'b0;
            redirect_o     = 1'b0;
        end else begin
            pc_we_o        = pc_we;
            if_id_stall_o  = if_id_stall;
            if_id_flush_o  = if_id_flush;
            id_ex_stall_o  = id_ex_stall;
            id_ex_flush_o  = id_ex_flush;
            ex_mem_stall_o = ex_mem_stall;
            ex_mem_flush_o = ex_mem_flush;
            mem_wb_flush_o = mem_wb_flush;
            redirect_o     = redirect;
        end
    end

    // The first response after a redirect with a fetch in flight belongs to
    // the old path and must be discarded.
    always_comb begin
        state_d = state_q;
        if (redirect && imem_wait) state_d = DROP;
        else if (stale_rsp)        state_d = IDLE;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr_i) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (!pc_we && (stall_cnt_q != '1))
                stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
            if (redirect && (flush_cnt_q != '1))
                flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: doc/pipeline_ctrl_unit.md
# pipeline_ctrl_unit

Central stall/flush controller for the 5-stage core, replacing the fixed load-use detector and the ad-hoc flush wiring at core top. It adds variable-latency instruction/data memory handshakes, a multi-cycle EX unit, selectable branch-resolution stage (ID or EX), stale-fetch squashing after a redirect, and saturating stall/flush performance counters. It sits beside the pipeline registers and drives their stall/flush controls and the PC write-enable.

## Interface
- BRANCH_IN_ID, 0: 0 = branches resolve in EX (flush IF/ID + ID/EX); 1 = resolve in ID (flush IF/ID only, extra dependency stalls)
- REG_ADDR_WIDTH, 5: register address width
- CNT_WIDTH, 32: performance counter width
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- rs1_addr_id_i / rs2_addr_id_i  in  REG_ADDR_WIDTH  source regs of instruction in ID
- rs1_used_id_i / rs2_used_id_i  in  1  source actually read
- is_branch_id_i  in  1  ID holds branch/JALR (used only when BRANCH_IN_ID=1)
- rd_addr_ex_i, RegWrite_ex_i, is_load_ex_i  in  REG_ADDR_WIDTH/1/1  EX destination info
- rd_addr_mem_i, is_load_mem_i  in  REG_ADDR_WIDTH/1  MEM destination info
- PCSrc_i  in  1  redirect request from resolving stage
- fetch_pending_i  in  1  IF has an outstanding imem request
- imem_rvalid_i  in  1  fetch response valid this cycle
- dmem_busy_i  in  1  MEM stage waiting on data memory
- ex_busy_i  in  1  multi-cycle EX op not finished
- cnt_clr_i  in  1  synchronous counter clear
- pc_we_o  out  1  PC write-enable
- if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_flush_o, ex_mem_stall_o, ex_mem_flush_o, mem_wb_flush_o  out  1 each
- redirect_o  out  1  accepted redirect (PC loads target)
- stall_cnt_o, flush_cnt_o  out  CNT_WIDTH  counters

## Operation
- Priority, highest first: dmem freeze, EX busy, redirect, dependency stall, imem wait.
- dmem_busy_i: PC, IF/ID, ID/EX, EX/MEM stall; mem_wb_flush_o=1; PCSrc_i ignored (resolving stage holds it).
- ex_busy_i: PC, IF/ID, ID/EX stall; ex_mem_flush_o=1; PCSrc_i ignored.
- Redirect (PCSrc_i, no freeze): redirect_o=1, pc_we_o=1, if_id_flush_o=1; id_ex_flush_o=1 when BRANCH_IN_ID=0. Overrides dependency stall and imem wait.
- Dependency stall (match = used source equals rd, rd≠0): load in EX with RegWrite_ex_i; BRANCH_IN_ID=1 also: branch in ID vs any RegWrite_ex_i, or vs load in MEM. Action: PC, IF/ID stall; id_ex_flush_o=1.
- Imem wait (fetch_pending_i & !imem_rvalid_i): pc_we_o=0, if_id_flush_o=1; downstream flows.
- Redirect FSM: IDLE -> DROP when redirect accepted while fetch_pending_i & !imem_rvalid_i. In DROP the next imem_rvalid_i is stale: if_id_flush_o=1, pc_we_o=0, return IDLE. Second redirect in DROP stays DROP. Freeze does not affect FSM.
- stall_cnt_o +1 each cycle pc_we_o=0; flush_cnt_o +1 per redirect_o; both saturate at all-ones; cnt_clr_i wins over increment.

## Timing
- All stall/flush/pc_we/redirect outputs combinational from inputs and FSM state; zero latency.
- rst_n low: FSM IDLE, counters 0, pc_we_o=0, all flushes 0, all stalls 1, redirect_o=0. Reset mid-DROP returns to IDLE; stale response after release is not dropped (IF resets too).
- Load-use costs exactly 1 bubble; ID-branch on ALU result 1 bubble, on load 2.
- Counters update on clk rising edge after the qualifying cycle.

## Structure
- core_pkg: hazard_cause_e (NONE, DMEM, EXBUSY, REDIRECT, DEP, IMEM), redir_state_e (IDLE, DROP).
- Sub-module hazard_dep_check: combinational source/destination matching, outputs dep_stall.
- Top computes cause, drives outputs via case on cause; holds FSM and counters.

## Test plan
- Load x5 in EX, ID uses x5 -> 1 cycle pc_we_o=0, id_ex_flush_o=1; rd=x0 -> no stall.
- PCSrc_i with load-use same cycle, BRANCH_IN_ID=0 -> redirect_o=1, if_id/id_ex flush, no stall, flush_cnt_o=1.
- Redirect while fetch pending, rvalid 3 cycles later -> DROP; that response flushed, FSM IDLE.
- dmem_busy_i 4 cycles with PCSrc_i held -> no redirect, mem_wb_flush_o=1 ×4; redirect on 5th; stall_cnt_o=4.
- BRANCH_IN_ID=1, branch on x7, load x7 in EX -> 2 bubbles; ALU write -> 1.
- stall_cnt_o preset near all-ones (CNT_WIDTH=4) -> saturates at 15; cnt_clr_i -> 0; rst_n low mid-DROP -> IDLE, counters 0.
